fnd_scan_driver: RTL and testbench

//   Consumer side of the FND digit-scan path: steps a 4-digit common-anode 7-segment display,

---
 rtl/fnd_pkg.sv | 45 ++++
 rtl/fnd_font_decoder.sv | 12 +
 rtl/fnd_scan_driver.sv | 95 +++++++++
 tb/tb_fnd_scan_driver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan path: segment bit positions, the active-low
// hex font table and the all-off codes for the segment and common lines.
package fnd_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] FONT_0 = 7'b1000000;
  localparam logic [6:0] FONT_1 = 7'b1111001;
  localparam logic [6:0] FONT_2 = 7'b0100100;
  localparam logic [6:0] FONT_3 = 7'b0110000;
  localparam logic [6:0] FONT_4 = 7'b0011001;
  localparam logic [6:0] FONT_5 = 7'b0010010;
  localparam logic [6:0] FONT_6 = 7'b0000010;
  localparam logic [6:0] FONT_7 = 7'b1111000;
  localparam logic [6:0] FONT_8 = 7'b0000000;
  localparam logic [6:0] FONT_9 = 7'b0010000;
  localparam logic [6:0] FONT_A = 7'b0001000;
  localparam logic [6:0] FONT_B = 7'b0000011;
  localparam logic [6:0] FONT_C = 7'b1000110;
  localparam logic [6:0] FONT_D = 7'b0100001;
  localparam logic [6:0] FONT_E = 7'b0000110;
  localparam logic [6:0] FONT_F = 7'b0001110;

  localparam logic [15:0][6:0] FONT_TABLE = {
    FONT_F, FONT_E, FONT_D, FONT_C, FONT_B, FONT_A, FONT_9, FONT_8,
    FONT_7, FONT_6, FONT_5, FONT_4, FONT_3, FONT_2, FONT_1, FONT_0
  };

  localparam logic [7:0] FND_OFF = 8'hFF;
  localparam logic [3:0] COM_OFF = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/fnd_font_decoder.sv
// Hex code plus decimal-point request to the active-low 8-bit segment pattern.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] font
);

  assign font = {~dp, FONT_TABLE[code]};

endmodule

// File: rtl/fnd_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode display with per-slot
// blanking and a frame-synchronous snapshot of the digit data.
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_digit_data,
  input  logic [3:0]  i_dp_mask,
  input  logic [3:0]  i_blank_mask,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_font,
  output logic [1:0]  o_digit_position,
  output logic        o_frame_done
);

  localparam int PERIOD = CLK_HZ / SCAN_HZ;
  localparam int PW     = (PERIOD < 2) ? 1 : $clog2(PERIOD);

  if (PERIOD < 2 || BLANK_CYCLES >= PERIOD) begin : g_param_check
    $fatal(1, "fnd_scan_driver: need PERIOD >= 2 and BLANK_CYCLES < PERIOD");
  end

  localparam scan_state_e ST_SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [1:0]    pos;
  scan_state_e   state;
  logic [15:0]   data_q;
  logic [3:0]    dp_q;
  logic [3:0]    blank_q;

  logic          wrap;
  logic          frame_start;
  logic [15:0]   data_eff;
  logic [3:0]    dp_eff;
  logic [3:0]    blank_eff;
  logic [7:0]    font_show;
  logic          dark;

  assign wrap        = (presc == PW'(PERIOD - 1));
  assign presc_next  = wrap ? '0 : presc + 1'b1;
  assign frame_start = (presc == '0) && (pos == 2'd0);

  // The first cycle of a frame already uses the inputs it captures, so the
  // digit-0 slot is correct even with no blanking ahead of it.
  assign data_eff  = frame_start ? i_digit_data : data_q;
  assign dp_eff    = frame_start ? i_dp_mask    : dp_q;
  assign blank_eff = frame_start ? i_blank_mask : blank_q;

  assign dark = (state == ST_BLANK) || blank_eff[pos];

  fnd_font_decoder u_dec (
    .code (data_eff[{pos, 2'b00} +: 4]),
    .dp   (dp_eff[pos]),
    .font (font_show)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      presc            <= '0;
      pos              <= 2'd0;
      state            <= ST_SLOT_START;
      data_q           <= '0;
      dp_q             <= '0;
      blank_q          <= '0;
      o_fnd_com        <= COM_OFF;
      o_fnd_font       <= FND_OFF;
      o_digit_position <= 2'd0;
      o_frame_done     <= 1'b0;
    end else begin
      presc <= presc_next;
      if (wrap) begin
        pos              <= pos + 2'd1;
        o_digit_position <= pos + 2'd1;
      end
      state <= (int'(presc_next) < BLANK_CYCLES) ? ST_BLANK : ST_SHOW;
      if (frame_start) begin
        data_q  <= i_digit_data;
        dp_q    <= i_dp_mask;
        blank_q <= i_blank_mask;
      end
      o_fnd_com  <= dark ? COM_OFF : ~(4'b0001 << pos);
      o_fnd_font <= dark ? FND_OFF : font_show;
      // high exactly during the wrap cycle of the digit-3 slot
      o_frame_done <= (presc == PW'(PERIOD - 2)) && (pos == 2'd3);
    end
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: two instances (blanking 2 and 0) against a
// cycle-index model, with literal pins for the key display patterns.
module tb_fnd_scan_driver;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int P       = CLK_HZ / SCAN_HZ;
  localparam int FRAME   = 4 * P;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [15:0] data  [2];
  logic [3:0]  dpm   [2];
  logic [3:0]  blm   [2];
  logic [3:0]  com   [2];
  logic [7:0]  font  [2];
  logic [1:0]  pos   [2];
  logic        fd    [2];

  fnd_scan_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYCLES(2)) dut0 (
    .i_clk(clk), .i_reset(rst_n[0]), .i_digit_data(data[0]), .i_dp_mask(dpm[0]),
    .i_blank_mask(blm[0]), .o_fnd_com(com[0]), .o_fnd_font(font[0]),
    .o_digit_position(pos[0]), .o_frame_done(fd[0])
  );

  fnd_scan_driver #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_CYCLES(0)) dut1 (
    .i_clk(clk), .i_reset(rst_n[1]), .i_digit_data(data[1]), .i_dp_mask(dpm[1]),
    .i_blank_mask(blm[1]), .o_fnd_com(com[1]), .o_fnd_font(font[1]),
    .o_digit_position(pos[1]), .o_frame_done(fd[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, inst, got, exp, $time);
    end
  endtask

  // ---- behavioural model: everything follows from the cycle index since reset
  bit          armed [2];
  int          kc    [2];
  logic [15:0] m_data [2];
  logic [3:0]  m_dp   [2];
  logic [3:0]  m_bl   [2];
  logic [3:0]  e_com  [2];
  logic [7:0]  e_font [2];
  logic [1:0]  e_pos  [2];
  logic        e_fd   [2];

  function automatic int blank_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic logic [11:0] pins(input int i, input int k);
    int p, ps;
    logic [3:0] c;
    logic [3:0] nib;
    p  = k % P;
    ps = (k / P) % 4;
    if (p < blank_of(i) || m_bl[i][ps]) return {4'hF, 8'hFF};
    c = 4'hF;
    c[ps] = 1'b0;
    nib = m_data[i][ps*4 +: 4];
    return {c, ~m_dp[i][ps], SEG[nib]};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (armed[i]) begin
        chk("com", i, 32'(com[i]), 32'(e_com[i]));
        chk("font", i, 32'(font[i]), 32'(e_font[i]));
        chk("pos", i, 32'(pos[i]), 32'(e_pos[i]));
        chk("frame_done", i, 32'(fd[i]), 32'(e_fd[i]));
      end
      if (rst_n[i] === 1'b0) begin
        armed[i] = 1'b1;
        kc[i]    = 0;
        e_com[i] = 4'hF; e_font[i] = 8'hFF; e_pos[i] = 2'd0; e_fd[i] = 1'b0;
      end else if (armed[i]) begin
        logic [11:0] pn;
        if (kc[i] % FRAME == 0) begin
          m_data[i] = data[i]; m_dp[i] = dpm[i]; m_bl[i] = blm[i];
        end
        pn = pins(i, kc[i]);
        e_com[i]  = pn[11:8];
        e_font[i] = pn[7:0];
        kc[i]     = kc[i] + 1;
        e_pos[i]  = 2'((kc[i] / P) % 4);
        e_fd[i]   = (kc[i] % P == P - 1) && ((kc[i] / P) % 4 == 3);
      end
    end
  end

  // ---- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    repeat (n) begin
      tick();
      @(negedge clk);
    end
  endtask

  int fd_cnt;
  int rcnt [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; dpm[i] = 4'h0; blm[i] = 4'h0;
    end
    data[0] = 16'h1234;
    data[1] = 16'hABCD;

    // test 1: reset hold, then release
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) begin rst_n[0] = 1'b1; rst_n[1] = 1'b1; end
      @(negedge clk);
      chk("rst_com", 0, 32'(com[0]), 32'h F);
      chk("rst_font", 0, 32'(font[0]), 32'h FF);
      chk("rst_pos", 0, 32'(pos[0]), 32'h0);
    end
    advance(1);  // k=1
    chk("noblank_com", 1, 32'(com[1]), 32'hE);
    chk("noblank_font_d", 1, 32'(font[1]), 32'hA1);
    chk("blank_com", 0, 32'(com[0]), 32'hF);
    advance(1);  // k=2
    chk("blank_com2", 0, 32'(com[0]), 32'hF);
    advance(1);  // k=3
    chk("d0_com", 0, 32'(com[0]), 32'hE);
    chk("d0_font4", 0, 32'(font[0]), 32'h99);

    // test 2: one full frame, frame_done once
    fd_cnt = 0;
    for (int k = 4; k < 44; k++) begin
      advance(1);
      if (fd[0] === 1'b1) fd_cnt++;
      if (k == 13) begin chk("d1_com", 0, 32'(com[0]), 32'hD); chk("d1_font3", 0, 32'(font[0]), 32'hB0); end
      if (k == 23) begin chk("d2_com", 0, 32'(com[0]), 32'hB); chk("d2_font2", 0, 32'(font[0]), 32'hA4); end
      if (k == 33) begin chk("d3_com", 0, 32'(com[0]), 32'h7); chk("d3_font1", 0, 32'(font[0]), 32'hF9); end
    end
    chk("frame_done_count", 0, 32'(fd_cnt), 32'd1);

    // test 3: data change mid-frame (k=52, digit-1 slot)
    advance(8);
    tick();
    data[0] = 16'h5678;
    @(negedge clk);
    advance(11);  // k=63
    chk("old_frame_font", 0, 32'(font[0]), 32'hA4);
    advance(20);  // k=83
    chk("new_frame_com", 0, 32'(com[0]), 32'hE);
    chk("new_frame_font8", 0, 32'(font[0]), 32'h80);

    // test 4: dp on digit 2, digit 3 blanked
    tick();
    dpm[0] = 4'b0100;
    blm[0] = 4'b1000;
    @(negedge clk);  // k=84
    advance(59);     // k=143
    chk("dp_com", 0, 32'(com[0]), 32'hB);
    chk("dp_font6", 0, 32'(font[0]), 32'h02);
    advance(7);      // k=150
    for (int k = 151; k <= 160; k++) begin
      advance(1);
      chk("blanked_com", 0, 32'(com[0]), 32'hF);
      chk("blanked_font", 0, 32'(font[0]), 32'hFF);
    end

    // test 5: reset during cycle 6 of the digit-2 slot
    advance(25);     // k=185
    tick();
    rst_n[0] = 1'b0; // k=186
    @(negedge clk);
    tick();
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("midrst_com", 0, 32'(com[0]), 32'hF);
    chk("midrst_pos", 0, 32'(pos[0]), 32'h0);
    advance(3);
    chk("restart_com", 0, 32'(com[0]), 32'hE);
    chk("restart_font8", 0, 32'(font[0]), 32'h80);

    // randomized phase, checked by the model every cycle
    rcnt[0] = 0; rcnt[1] = 0;
    repeat (3000) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) data[i] = 16'($urandom);
        if ($urandom_range(0, 15) == 0) dpm[i] = 4'($urandom);
        if ($urandom_range(0, 15) == 0) blm[i] = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
        if (rcnt[i] > 0) begin
          rcnt[i]--;
          rst_n[i] = 1'b0;
        end else begin
          rst_n[i] = 1'b1;
          if ($urandom_range(0, 299) == 0) rcnt[i] = $urandom_range(1, 3);
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
